// File: rtl/packet_loader.sv
// packet_loader: fetch stage of the dataflow core.
// Accepts a packet request, reads the 175-bit instruction template from
// instruction memory as six 32-bit words starting at OPADDR + dest_addr,
// merges the request colour/operands into it and hands the finished packet
// to the queue (EI), fetch (FN) or memory-access (MA) unit by opmode.
// Only one request and one memory read are ever in flight.
module packet_loader #(
  parameter int         PACKET_WIDTH         = 175,
  parameter int         PACKET_REQUEST_WIDTH = 147,
  parameter logic [1:0] OPCODE_EI            = 2'd0,
  parameter logic [1:0] OPCODE_FN            = 2'd1,
  parameter logic [1:0] OPCODE_MA            = 2'd2,
  parameter logic [2:0] DEST_OPTION_EXEC     = 3'd0,
  parameter logic [2:0] DEST_OPTION_LEFT     = 3'd1,
  parameter logic [2:0] DEST_OPTION_RIGHT    = 3'd2
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [31:0]                     OPADDR,

  output logic                            MEM_SEND_ADDR_VALID,
  output logic [31:0]                     MEM_SEND_ADDR,
  input  logic                            MEM_SEND_READY,
  output logic                            MEM_SEND_DATA_VALID,
  output logic [31:0]                     MEM_SEND_DATA,

  input  logic                            MEM_RECEIVE_VALID,
  input  logic [31:0]                     MEM_RECEIVE_DATA,
  output logic                            MEM_RECEIVE_READY,

  input  logic                            RECEIVE_PR_VALID,
  input  logic [PACKET_REQUEST_WIDTH-1:0] RECEIVE_PR_DATA,
  output logic                            RECEIVE_PR_READY,

  output logic                            SEND_PC_TO_QU_VALID,
  output logic [PACKET_WIDTH-1:0]         SEND_PC_TO_QU_DATA,
  input  logic                            SEND_PC_TO_QU_READY,

  output logic                            SEND_PC_TO_FE_VALID,
  output logic [PACKET_WIDTH-1:0]         SEND_PC_TO_FE_DATA,
  input  logic                            SEND_PC_TO_FE_READY,

  output logic                            SEND_PC_TO_MA_VALID,
  output logic [PACKET_WIDTH-1:0]         SEND_PC_TO_MA_DATA,
  input  logic                            SEND_PC_TO_MA_READY
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    SEND = 2'd3
  } state_t;

  localparam logic [2:0] LAST_WORD = 3'd5;

  state_t                          state_q;
  logic [2:0]                      k_q;
  logic [PACKET_REQUEST_WIDTH-1:0] req_q;
  // Template bits [14:0] arrive with the last word and go straight into the
  // merged packet, so only the upper 160 bits are ever held here.
  logic [174:15]                   tmpl_q;
  logic [PACKET_WIDTH-1:0]         pkt_q;

  logic                            addr_valid_q;
  logic [31:0]                     addr_q;
  logic                            recv_ready_q;
  logic                            pr_ready_q;
  logic                            qu_valid_q;
  logic                            fe_valid_q;
  logic                            ma_valid_q;

  logic [2:0]                      k_next;
  logic [31:0]                     first_addr;
  logic [31:0]                     next_addr;
  logic [PACKET_WIDTH-1:0]         merged_pkt;
  logic                            out_fire;

  // Replace the colour and, depending on the destination option, the
  // operand fields of the template with the values carried by the request.
  function automatic logic [174:0] merge_packet(input logic [174:0] tmpl,
                                                input logic [146:0] req);
    logic [174:0] pkt;
    pkt          = tmpl;
    pkt[127:64]  = req[127:64];
    case (req[146:144])
      DEST_OPTION_EXEC: begin
        pkt[63:32] = req[63:32];
        pkt[31:0]  = req[31:0];
      end
      DEST_OPTION_LEFT: begin
        pkt[63:32] = req[63:32];
      end
      DEST_OPTION_RIGHT: begin
        pkt[31:0]  = req[31:0];
      end
      default: begin
      end
    endcase
    return pkt;
  endfunction

  // Address arithmetic and the merged packet built from the incoming last word.
  always_comb begin
    k_next     = k_q + 3'd1;
    first_addr = OPADDR + {16'd0, RECEIVE_PR_DATA[143:128]};
    next_addr  = OPADDR + {16'd0, req_q[143:128]} + {27'd0, k_next, 2'b00};
    merged_pkt = merge_packet({tmpl_q, MEM_RECEIVE_DATA[14:0]}, req_q);
    out_fire   = (qu_valid_q & SEND_PC_TO_QU_READY) |
                 (fe_valid_q & SEND_PC_TO_FE_READY) |
                 (ma_valid_q & SEND_PC_TO_MA_READY);
  end

  // Fetch FSM: request -> six address/data round trips -> routed output.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      k_q          <= 3'd0;
      req_q        <= '0;
      tmpl_q       <= '0;
      pkt_q        <= '0;
      addr_valid_q <= 1'b0;
      addr_q       <= 32'd0;
      recv_ready_q <= 1'b0;
      pr_ready_q   <= 1'b0;
      qu_valid_q   <= 1'b0;
      fe_valid_q   <= 1'b0;
      ma_valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pr_ready_q <= 1'b1;
          if (RECEIVE_PR_VALID && pr_ready_q) begin
            req_q        <= RECEIVE_PR_DATA;
            k_q          <= 3'd0;
            addr_q       <= first_addr;
            addr_valid_q <= 1'b1;
            pr_ready_q   <= 1'b0;
            state_q      <= ADDR;
          end
        end

        ADDR: begin
          if (addr_valid_q && MEM_SEND_READY) begin
            addr_valid_q <= 1'b0;
            recv_ready_q <= 1'b1;
            state_q      <= DATA;
          end
        end

        DATA: begin
          if (recv_ready_q && MEM_RECEIVE_VALID) begin
            recv_ready_q <= 1'b0;
            if (k_q != LAST_WORD) begin
              case (k_q)
                3'd0:    tmpl_q[174:143] <= MEM_RECEIVE_DATA;
                3'd1:    tmpl_q[142:111] <= MEM_RECEIVE_DATA;
                3'd2:    tmpl_q[110:79]  <= MEM_RECEIVE_DATA;
                3'd3:    tmpl_q[78:47]   <= MEM_RECEIVE_DATA;
                default: tmpl_q[46:15]   <= MEM_RECEIVE_DATA;
              endcase
              k_q          <= k_next;
              addr_q       <= next_addr;
              addr_valid_q <= 1'b1;
              state_q      <= ADDR;
            end else begin
              pkt_q <= merged_pkt;
              case (tmpl_q[174:173])
                OPCODE_EI: begin
                  qu_valid_q <= 1'b1;
                  state_q    <= SEND;
                end
                OPCODE_FN: begin
                  fe_valid_q <= 1'b1;
                  state_q    <= SEND;
                end
                OPCODE_MA: begin
                  ma_valid_q <= 1'b1;
                  state_q    <= SEND;
                end
                default: begin
                  // Reserved opmode: the packet has no consumer and is dropped.
                  pr_ready_q <= 1'b1;
                  state_q    <= IDLE;
                end
              endcase
            end
          end
        end

        SEND: begin
          if (out_fire) begin
            qu_valid_q <= 1'b0;
            fe_valid_q <= 1'b0;
            ma_valid_q <= 1'b0;
            pr_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign MEM_SEND_ADDR_VALID = addr_valid_q;
  assign MEM_SEND_ADDR       = addr_q;
  assign MEM_SEND_DATA_VALID = 1'b0;
  assign MEM_SEND_DATA       = 32'd0;
  assign MEM_RECEIVE_READY   = recv_ready_q;
  assign RECEIVE_PR_READY    = pr_ready_q;

  assign SEND_PC_TO_QU_VALID = qu_valid_q;
  assign SEND_PC_TO_FE_VALID = fe_valid_q;
  assign SEND_PC_TO_MA_VALID = ma_valid_q;
  assign SEND_PC_TO_QU_DATA  = qu_valid_q ? pkt_q : '0;
  assign SEND_PC_TO_FE_DATA  = fe_valid_q ? pkt_q : '0;
  assign SEND_PC_TO_MA_DATA  = ma_valid_q ? pkt_q : '0;

endmodule

// File: tb/tb_packet_loader.sv
// Testbench for packet_loader: directed vector table, reset/abort sequence
// and a randomised sweep over opmodes and destination options, with a
// memory responder that also checks the address stream.
module tb_packet_loader;

  logic         CLK;
  logic         RST;
  logic [31:0]  OPADDR;
  logic         MEM_SEND_ADDR_VALID;
  logic [31:0]  MEM_SEND_ADDR;
  logic         MEM_SEND_READY;
  logic         MEM_SEND_DATA_VALID;
  logic [31:0]  MEM_SEND_DATA;
  logic         MEM_RECEIVE_VALID;
  logic [31:0]  MEM_RECEIVE_DATA;
  logic         MEM_RECEIVE_READY;
  logic         RECEIVE_PR_VALID;
  logic [146:0] RECEIVE_PR_DATA;
  logic         RECEIVE_PR_READY;
  logic         SEND_PC_TO_QU_VALID;
  logic [174:0] SEND_PC_TO_QU_DATA;
  logic         SEND_PC_TO_QU_READY;
  logic         SEND_PC_TO_FE_VALID;
  logic [174:0] SEND_PC_TO_FE_DATA;
  logic         SEND_PC_TO_FE_READY;
  logic         SEND_PC_TO_MA_VALID;
  logic [174:0] SEND_PC_TO_MA_DATA;
  logic         SEND_PC_TO_MA_READY;

  packet_loader dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .OPADDR              (OPADDR),
    .MEM_SEND_ADDR_VALID (MEM_SEND_ADDR_VALID),
    .MEM_SEND_ADDR       (MEM_SEND_ADDR),
    .MEM_SEND_READY      (MEM_SEND_READY),
    .MEM_SEND_DATA_VALID (MEM_SEND_DATA_VALID),
    .MEM_SEND_DATA       (MEM_SEND_DATA),
    .MEM_RECEIVE_VALID   (MEM_RECEIVE_VALID),
    .MEM_RECEIVE_DATA    (MEM_RECEIVE_DATA),
    .MEM_RECEIVE_READY   (MEM_RECEIVE_READY),
    .RECEIVE_PR_VALID    (RECEIVE_PR_VALID),
    .RECEIVE_PR_DATA     (RECEIVE_PR_DATA),
    .RECEIVE_PR_READY    (RECEIVE_PR_READY),
    .SEND_PC_TO_QU_VALID (SEND_PC_TO_QU_VALID),
    .SEND_PC_TO_QU_DATA  (SEND_PC_TO_QU_DATA),
    .SEND_PC_TO_QU_READY (SEND_PC_TO_QU_READY),
    .SEND_PC_TO_FE_VALID (SEND_PC_TO_FE_VALID),
    .SEND_PC_TO_FE_DATA  (SEND_PC_TO_FE_DATA),
    .SEND_PC_TO_FE_READY (SEND_PC_TO_FE_READY),
    .SEND_PC_TO_MA_VALID (SEND_PC_TO_MA_VALID),
    .SEND_PC_TO_MA_DATA  (SEND_PC_TO_MA_DATA),
    .SEND_PC_TO_MA_READY (SEND_PC_TO_MA_READY)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] cur_opaddr;
  logic [15:0] cur_dest;
  logic [31:0] cur_words [6];
  int          exp_idx;
  bit          stall_en;

  localparam logic [31:0] A  = 32'hAAAA_0001;
  localparam logic [31:0] B  = 32'hBBBB_5A5A;
  localparam logic [31:0] C  = 32'hCCCC_0003;
  localparam logic [31:0] D  = 32'hDDDD_0004;
  localparam logic [63:0] E  = 64'hEEEE_0000_EEEE_0001;
  localparam logic [63:0] TC = 64'h1111_2222_3333_4444;

  typedef struct {
    logic [31:0] opaddr;
    logic [1:0]  t_opmode;
    logic [6:0]  t_opcode;
    logic [2:0]  t_d1_opt;
    logic [15:0] t_d1_addr;
    logic [2:0]  t_d2_opt;
    logic [15:0] t_d2_addr;
    logic [63:0] t_color;
    logic [31:0] t_data1;
    logic [31:0] t_data2;
    logic [16:0] filler;
    logic [2:0]  r_opt;
    logic [15:0] r_dest;
    logic [63:0] r_color;
    logic [31:0] r_data1;
    logic [31:0] r_data2;
    bit          stall;
    bit          early;
    bit          check_lat;
    int          exp_port;
    logic [31:0] exp_d1;
    logic [31:0] exp_d2;
  } vec_t;

  vec_t vecs [7];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [174:0] act,
                             input logic [174:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [174:0] golden(input logic [174:0] t,
                                          input logic [146:0] r);
    logic [31:0] d1;
    logic [31:0] d2;
    logic [2:0]  opt;
    opt = r[146:144];
    d1  = (opt == 3'd0 || opt == 3'd1) ? r[63:32] : t[63:32];
    d2  = (opt == 3'd0 || opt == 3'd2) ? r[31:0]  : t[31:0];
    return {t[174:128], r[127:64], d1, d2};
  endfunction

  task automatic loadTemplate(input logic [31:0] opaddr, input logic [174:0] t,
                              input logic [16:0] filler, input logic [15:0] dest);
    cur_opaddr   = opaddr;
    cur_dest     = dest;
    cur_words[0] = t[174:143];
    cur_words[1] = t[142:111];
    cur_words[2] = t[110:79];
    cur_words[3] = t[78:47];
    cur_words[4] = t[46:15];
    cur_words[5] = {filler, t[14:0]};
    exp_idx      = 0;
    OPADDR       = opaddr;
  endtask

  // Memory responder: answers each read with the current template word,
  // optionally stalling, and checks the address order and values.
  initial begin : mem_responder
    bit          addr_fire;
    bit          data_fire;
    bit          data_busy;
    int          wait_cnt;
    logic [31:0] exp_addr;
    logic [31:0] held_word;
    addr_fire = 0;
    data_fire = 0;
    data_busy = 0;
    wait_cnt  = 0;
    held_word = '0;
    MEM_SEND_READY    = 1'b0;
    MEM_RECEIVE_VALID = 1'b0;
    MEM_RECEIVE_DATA  = '0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        addr_fire         = 0;
        data_fire         = 0;
        data_busy         = 0;
        MEM_SEND_READY    = 1'b0;
        MEM_RECEIVE_VALID = 1'b0;
        MEM_RECEIVE_DATA  = '0;
      end else begin
        if (data_fire) begin
          data_fire         = 0;
          data_busy         = 0;
          MEM_RECEIVE_VALID = 1'b0;
          MEM_RECEIVE_DATA  = '0;
        end
        if (addr_fire) begin
          addr_fire = 0;
          data_busy = 1;
          wait_cnt  = stall_en ? int'($urandom_range(0, 2)) : 0;
        end
        if (data_busy && !MEM_RECEIVE_VALID) begin
          if (wait_cnt == 0) begin
            MEM_RECEIVE_VALID = 1'b1;
            MEM_RECEIVE_DATA  = held_word;
          end else begin
            wait_cnt--;
          end
        end
        MEM_SEND_READY = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
        if (MEM_SEND_ADDR_VALID && MEM_SEND_READY) begin
          addr_fire = 1;
          checkOutput("addr_order", {174'd0, data_busy}, 175'd0);
          if (exp_idx < 6) begin
            exp_addr  = cur_opaddr + {16'h0, cur_dest} + 32'(exp_idx * 4);
            checkOutput("mem_addr", {143'd0, MEM_SEND_ADDR}, {143'd0, exp_addr});
            held_word = cur_words[exp_idx];
            exp_idx++;
          end else begin
            checkOutput("extra_addr", 175'(exp_idx), 175'd5);
          end
        end
        if (MEM_RECEIVE_VALID && MEM_RECEIVE_READY) data_fire = 1;
      end
    end
  end

  // Drive one request, wait for the routed output, stall it and check it.
  task automatic applyStimulus(input string tag, input logic [31:0] opaddr,
                               input logic [174:0] t, input logic [16:0] filler,
                               input logic [146:0] req, input int exp_port,
                               input logic [174:0] exp_pkt, input bit stall,
                               input bit early, input bit check_lat);
    int          cyc;
    int          nv;
    int          port;
    int          stalls;
    logic [174:0] got;
    @(negedge CLK);
    stall_en = stall;
    loadTemplate(opaddr, t, filler, req[143:128]);
    RECEIVE_PR_DATA  = req;
    RECEIVE_PR_VALID = 1'b1;
    cyc = 0;
    while (!RECEIVE_PR_READY && cyc < 50) begin
      @(negedge CLK);
      cyc++;
    end
    if (!RECEIVE_PR_READY) begin
      checkOutput({tag, "_req_timeout"}, 175'(RECEIVE_PR_READY), 175'd1);
      RECEIVE_PR_VALID = 1'b0;
      return;
    end
    @(negedge CLK);
    RECEIVE_PR_VALID    = 1'b0;
    SEND_PC_TO_QU_READY = early;
    SEND_PC_TO_FE_READY = early;
    SEND_PC_TO_MA_READY = early;
    cyc = 1;
    while (cyc < 300) begin
      if (SEND_PC_TO_QU_VALID || SEND_PC_TO_FE_VALID || SEND_PC_TO_MA_VALID) break;
      if (exp_port == 3 && RECEIVE_PR_READY) break;
      @(negedge CLK);
      cyc++;
    end
    if (cyc >= 300) begin
      checkOutput({tag, "_out_timeout"}, 175'(cyc), 175'd0);
      return;
    end
    if (check_lat) checkOutput({tag, "_latency"}, 175'(cyc), 175'd13);
    nv = int'(SEND_PC_TO_QU_VALID) + int'(SEND_PC_TO_FE_VALID) + int'(SEND_PC_TO_MA_VALID);
    if (nv > 1)                   port = 4;
    else if (SEND_PC_TO_QU_VALID) port = 0;
    else if (SEND_PC_TO_FE_VALID) port = 1;
    else if (SEND_PC_TO_MA_VALID) port = 2;
    else                          port = 3;
    checkOutput({tag, "_route"}, 175'(port), 175'(exp_port));
    if (port < 3) begin
      stalls = (stall && !early) ? int'($urandom_range(1, 3)) : 0;
      for (int s = 0; s < stalls; s++) @(negedge CLK);
      case (port)
        0:       begin got = SEND_PC_TO_QU_DATA; nv = int'(SEND_PC_TO_QU_VALID); SEND_PC_TO_QU_READY = 1'b1; end
        1:       begin got = SEND_PC_TO_FE_DATA; nv = int'(SEND_PC_TO_FE_VALID); SEND_PC_TO_FE_READY = 1'b1; end
        default: begin got = SEND_PC_TO_MA_DATA; nv = int'(SEND_PC_TO_MA_VALID); SEND_PC_TO_MA_READY = 1'b1; end
      endcase
      checkOutput({tag, "_valid_hold"}, 175'(nv), 175'd1);
      checkOutput({tag, "_packet"}, got, exp_pkt);
      @(negedge CLK);
      SEND_PC_TO_QU_READY = 1'b0;
      SEND_PC_TO_FE_READY = 1'b0;
      SEND_PC_TO_MA_READY = 1'b0;
      checkOutput({tag, "_next_ready"},
                  {172'd0, RECEIVE_PR_READY, SEND_PC_TO_QU_VALID | SEND_PC_TO_FE_VALID | SEND_PC_TO_MA_VALID, 1'b0},
                  {172'd0, 1'b1, 1'b0, 1'b0});
    end
    SEND_PC_TO_QU_READY = 1'b0;
    SEND_PC_TO_FE_READY = 1'b0;
    SEND_PC_TO_MA_READY = 1'b0;
  endtask

  function automatic logic [174:0] vecTemplate(input vec_t v);
    return {v.t_opmode, v.t_opcode, v.t_d1_opt, v.t_d1_addr, v.t_d2_opt,
            v.t_d2_addr, v.t_color, v.t_data1, v.t_data2};
  endfunction

  function automatic logic [146:0] vecRequest(input vec_t v);
    return {v.r_opt, v.r_dest, v.r_color, v.r_data1, v.r_data2};
  endfunction

  function automatic logic [174:0] vecExpected(input vec_t v);
    return {v.t_opmode, v.t_opcode, v.t_d1_opt, v.t_d1_addr, v.t_d2_opt,
            v.t_d2_addr, v.r_color, v.exp_d1, v.exp_d2};
  endfunction

  // Main sequence: reset, directed table, abort-by-reset, random sweep.
  initial begin : main_seq
    logic [174:0] t;
    logic [146:0] r;
    logic [31:0]  w [13];
    logic [16:0]  filler;

    vecs[0] = '{32'h2000_0000, 2'd0, 7'h15, 3'd1, 16'h1234, 3'd2, 16'h5678, TC, A, B, 17'h00000,
                3'd0, 16'h0010, E, C, D, 1'b0, 1'b0, 1'b1, 0, C, D};
    vecs[1] = '{32'h2000_0000, 2'd1, 7'h22, 3'd0, 16'h0F0F, 3'd3, 16'hF0F0, TC, A, B, 17'h1FFFF,
                3'd1, 16'h0010, E, C, D, 1'b1, 1'b0, 1'b0, 1, C, B};
    vecs[2] = '{32'h3000_0100, 2'd2, 7'h7F, 3'd2, 16'hBEEF, 3'd1, 16'hCAFE, TC, A, B, 17'h0AAAA,
                3'd2, 16'h0040, E, C, D, 1'b1, 1'b0, 1'b0, 2, A, D};
    vecs[3] = '{32'h2000_0000, 2'd0, 7'h01, 3'd4, 16'h0001, 3'd5, 16'h0002, TC, A, B, 17'h15555,
                3'd5, 16'h0100, E, C, D, 1'b0, 1'b1, 1'b0, 0, A, B};
    vecs[4] = '{32'h2000_0000, 2'd3, 7'h33, 3'd1, 16'h1111, 3'd1, 16'h2222, TC, A, B, 17'h00001,
                3'd0, 16'h0020, E, C, D, 1'b0, 1'b0, 1'b0, 3, C, D};
    vecs[5] = '{32'hFFFF_FFF0, 2'd2, 7'h44, 3'd2, 16'h3333, 3'd2, 16'h4444, TC, A, B, 17'h0F00F,
                3'd0, 16'hFFFF, E, C, D, 1'b1, 1'b0, 1'b0, 2, C, D};
    vecs[6] = '{32'h0000_1000, 2'd1, 7'h5A, 3'd7, 16'h5555, 3'd6, 16'h6666, TC, A, B, 17'h1F0F0,
                3'd7, 16'h0004, E, C, D, 1'b0, 1'b0, 1'b1, 1, A, B};

    RST                 = 1'b1;
    OPADDR              = '0;
    RECEIVE_PR_VALID    = 1'b0;
    RECEIVE_PR_DATA     = '0;
    SEND_PC_TO_QU_READY = 1'b0;
    SEND_PC_TO_FE_READY = 1'b0;
    SEND_PC_TO_MA_READY = 1'b0;
    stall_en            = 1'b0;
    exp_idx             = 0;
    cur_opaddr          = '0;
    cur_dest            = '0;
    for (int i = 0; i < 6; i++) cur_words[i] = '0;

    repeat (3) @(negedge CLK);
    checkOutput("reset_handshakes",
                {169'd0, RECEIVE_PR_READY, MEM_SEND_ADDR_VALID, MEM_RECEIVE_READY,
                 SEND_PC_TO_QU_VALID, SEND_PC_TO_FE_VALID, SEND_PC_TO_MA_VALID}, 175'd0);
    checkOutput("reset_data", SEND_PC_TO_QU_DATA | SEND_PC_TO_FE_DATA | SEND_PC_TO_MA_DATA |
                {143'd0, MEM_SEND_ADDR}, 175'd0);
    checkOutput("mem_write_tied", {142'd0, MEM_SEND_DATA_VALID, MEM_SEND_DATA}, 175'd0);
    RST = 1'b0;
    @(negedge CLK);
    checkOutput("pr_ready_rise", 175'(RECEIVE_PR_READY), 175'd1);

    for (int i = 0; i < 7; i++) begin
      applyStimulus($sformatf("v%0d", i), vecs[i].opaddr, vecTemplate(vecs[i]),
                    vecs[i].filler, vecRequest(vecs[i]), vecs[i].exp_port,
                    vecExpected(vecs[i]), vecs[i].stall, vecs[i].early, vecs[i].check_lat);
    end

    // Reset in the middle of a fetch must abandon it cleanly.
    @(negedge CLK);
    stall_en = 1'b0;
    loadTemplate(vecs[0].opaddr, vecTemplate(vecs[0]), vecs[0].filler, vecs[0].r_dest);
    RECEIVE_PR_DATA  = vecRequest(vecs[0]);
    RECEIVE_PR_VALID = 1'b1;
    @(negedge CLK);
    RECEIVE_PR_VALID = 1'b0;
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    checkOutput("abort_outputs",
                {169'd0, RECEIVE_PR_READY, MEM_SEND_ADDR_VALID, MEM_RECEIVE_READY,
                 SEND_PC_TO_QU_VALID, SEND_PC_TO_FE_VALID, SEND_PC_TO_MA_VALID}, 175'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    applyStimulus("after_abort", vecs[2].opaddr, vecTemplate(vecs[2]), vecs[2].filler,
                  vecRequest(vecs[2]), vecs[2].exp_port, vecExpected(vecs[2]),
                  1'b0, 1'b0, 1'b1);

    // Random sweep: every opmode against every real destination option.
    for (int it = 0; it < 10; it++) begin
      for (int m = 0; m < 3; m++) begin
        for (int o = 0; o < 3; o++) begin
          for (int j = 0; j < 13; j++) w[j] = $urandom();
          filler = w[12][16:0];
          t = {2'(m), w[0], w[1], w[2], w[3], w[4], w[5][12:0]};
          r = {3'(o), w[6][15:0], w[7], w[8], w[9], w[10]};
          applyStimulus($sformatf("rnd%0d_m%0d_o%0d", it, m, o), w[11], t, filler, r,
                        m, golden(t, r), 1'b1, 1'b0, 1'b0);
        end
      end
    end

    repeat (2) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/packet_loader.md
# packet_loader

Fetch stage of the dataflow core. It accepts a packet request (destination option, instruction address, color, operand data) and reads the 175-bit instruction template from memory as six 32-bit words at `OPADDR + dest_addr`. It merges the request into the template and forwards the finished packet to the queue, fetch or memory-access unit according to the template's opmode.

## Interface
- `PACKET_WIDTH`, 175, packet width: opmode[174:173], opcode[172:166], d1_opt[165:163], d1_addr[162:147], d2_opt[146:144], d2_addr[143:128], color[127:64], data1[63:32], data2[31:0].
- `PACKET_REQUEST_WIDTH`, 147, request width: dest_option[146:144], dest_addr[143:128], color[127:64], data1[63:32], data2[31:0].
- `OPCODE_EI`/`OPCODE_FN`/`OPCODE_MA`, 0/1/2, opmode codes (3 reserved).
- `DEST_OPTION_EXEC`/`DEST_OPTION_LEFT`/`DEST_OPTION_RIGHT`, 0/1/2, destination options.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `OPADDR` in 32: instruction-memory base address.
- `MEM_SEND_ADDR_VALID` out 1 / `MEM_SEND_ADDR` out 32 / `MEM_SEND_READY` in 1: read-address channel.
- `MEM_SEND_DATA_VALID` out 1 / `MEM_SEND_DATA` out 32: write-data channel, tied to 0 (read-only block).
- `MEM_RECEIVE_VALID` in 1 / `MEM_RECEIVE_DATA` in 32 / `MEM_RECEIVE_READY` out 1: read-data channel.
- `RECEIVE_PR_VALID` in 1 / `RECEIVE_PR_DATA` in 147 / `RECEIVE_PR_READY` out 1: request input.
- `SEND_PC_TO_{QU,FE,MA}_VALID` out 1 / `_DATA` out 175 / `_READY` in 1: packet outputs to queue (EI), fetch (FN) and memory access (MA).

## Operation
- Every channel uses a valid/ready handshake. A transfer occurs at a rising edge where both valid and ready are high. Once raised, a valid stays high with stable data until that transfer.
- FSM states: IDLE, ADDR, DATA, SEND. Word counter k runs 0..5.
- IDLE: `RECEIVE_PR_READY`=1. On a request transfer, latch the request, set k=0 and go to ADDR.
- ADDR: `MEM_SEND_ADDR_VALID`=1 and `MEM_SEND_ADDR` = OPADDR + zero-extended dest_addr + 4k, mod 2^32. On the address transfer, go to DATA.
- DATA: `MEM_RECEIVE_READY`=1. On the data transfer:
  - k<5: store the word as template[174-32k -: 32], k+1, back to ADDR.
  - k=5: store bits [14:0] as template[14:0], ignore the upper 17 bits, go to SEND.
- Merge, applied on the output:
  - output = template with color replaced by request color.
  - EXEC: data1 and data2 both come from the request.
  - LEFT: data1 comes from the request, data2 from the template.
  - RIGHT: data2 comes from the request, data1 from the template.
  - Options 3-7: both data fields stay from the template.
- SEND: raise only the VALID selected by template opmode (EI→QU, FN→FE, MA→MA), hold until its READY, then go to IDLE. Opmode 3: drop the packet and return to IDLE without raising any output valid.
- Only one request is in flight at a time, and only one memory read is outstanding at a time.

## Timing
- While RST is high, and on the first edge after release: all VALID/READY outputs are 0, all data outputs are 0, and the FSM is in IDLE.
- `RECEIVE_PR_READY` rises in the first cycle after RST deasserts.
- Request transfer at edge N → ADDR valid from cycle N+1.
- Address transfer → `MEM_RECEIVE_READY` in the next cycle.
- Data transfer → next ADDR valid, or output valid after the sixth word, in the next cycle.
- Minimum latency from request to output valid: 13 cycles, with zero-wait memory.
- The next request is accepted the cycle after the output transfer.
- A READY arriving while its VALID is low is ignored.
- RST mid-operation aborts the fetch and discards the partial template.

## Test plan
- Reset: RST=1 with all inputs 0 → `RECEIVE_PR_READY`, `MEM_SEND_ADDR_VALID` and all three PC valids read 0.
- Address sequence: OPADDR=32'h2000_0000, dest_addr=16'h0010 → addresses 2000_0010, _0014, _0018, _001C, _0020, _0024, each issued only after the prior data transfer.
- Routing: opmode EI/FN/MA → only QU/FE/MA valid respectively, stalling until its READY.
- Merge: template data1=A, data2=B, request data1=C, data2=D, color=E → EXEC {C,D}, LEFT {C,B}, RIGHT {A,D}; color is E in every case.
- Last word: upper 17 bits of word 5 set to 1s → output bits [14:0] match, no corruption of other fields.
- Random stress: 10 iterations × 3 opmodes × 3 options with random memory/ready stalls → output equals the merged golden packet every time.
